// File: rtl/branch_predictor_bht_if.sv
// Fetch/EX signal bundle between the pipeline and the BHT direction predictor.
// The master is the pipeline side; the slave is the predictor.
interface branch_predictor_bht_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
);
  logic [PC_WIDTH-1:0]  if_pc;
  logic                 if_pred_taken;
  logic                 ex_valid;
  logic                 ex_is_branch;
  logic                 ex_br_type;
  logic [PC_WIDTH-1:0]  ex_pc;
  logic                 ex_zero;
  logic                 ex_pred_taken;
  logic                 ex_actual_taken;
  logic                 ex_mispredict;
  logic [CNT_WIDTH-1:0] branch_count;
  logic [CNT_WIDTH-1:0] mispredict_count;

  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_br_type, ex_pc, ex_zero, ex_pred_taken,
    input  if_pred_taken, ex_actual_taken, ex_mispredict, branch_count, mispredict_count
  );

  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_br_type, ex_pc, ex_zero, ex_pred_taken,
    output if_pred_taken, ex_actual_taken, ex_mispredict, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor_bht.sv
// 2-bit saturating-counter BHT: zero-latency fetch prediction, combinational EX resolve,
// table/perf-counter update on the clock edge; never stalls the pipeline.
module branch_predictor_bht #(
  parameter int INDEX_BITS = 6,
  parameter int PC_WIDTH   = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_predictor_bht_if.slave  bp
);
  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            bht_q [ENTRIES];
  logic [1:0]            entry_cur;
  logic [1:0]            entry_d;
  logic [INDEX_BITS-1:0] if_idx;
  logic [INDEX_BITS-1:0] ex_idx;
  logic                  update_en;
  logic                  actual_taken;
  logic                  mispredict;
  logic [CNT_WIDTH-1:0]  branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0]  mispredict_count_q, mispredict_count_d;

  // Word-aligned PCs: the low two bits carry no index information.
  assign if_idx = bp.if_pc[INDEX_BITS+1:2];
  assign ex_idx = bp.ex_pc[INDEX_BITS+1:2];

  assign update_en = bp.ex_valid & bp.ex_is_branch;

  always_comb begin
    actual_taken = 1'b0;
    if (update_en) begin
      actual_taken = bp.ex_br_type ? ~bp.ex_zero : bp.ex_zero;
    end
    mispredict = update_en & (actual_taken != bp.ex_pred_taken);
  end

  assign entry_cur = bht_q[ex_idx];

  always_comb begin
    entry_d = entry_cur;
    if (actual_taken) begin
      if (entry_cur != 2'b11) entry_d = entry_cur + 2'd1;
    end else begin
      if (entry_cur != 2'b00) entry_d = entry_cur - 2'd1;
    end
  end

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (update_en) begin
      if (branch_count_q != '1) branch_count_d = branch_count_q + 1'b1;
      if (mispredict && (mispredict_count_q != '1)) begin
        mispredict_count_d = mispredict_count_q + 1'b1;
      end
    end
  end

  // Entries reset to weak-NT, so the prediction reads 0 while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (update_en) begin
      bht_q[ex_idx] <= entry_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign bp.if_pred_taken    = bht_q[if_idx][1];
  assign bp.ex_actual_taken  = actual_taken;
  assign bp.ex_mispredict    = mispredict;
  assign bp.branch_count     = branch_count_q;
  assign bp.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Bench for branch_predictor_bht: vector table, scoreboard queue, and directed corner sequences.
module tb_branch_predictor_bht;
  logic clk;
  logic rst_n;

  branch_predictor_bht_if #(.PC_WIDTH(32), .CNT_WIDTH(32)) bp_if ();

  branch_predictor_bht #(.INDEX_BITS(6), .PC_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        b;
    logic        bt;
    logic        z;
    logic        p;
    logic [31:0] pc;
    logic        exp_act;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic        act;
    logic        mis;
    logic        ifp;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t        sb[$];
  int          tests;
  int          failed;
  logic [1:0]  mdl [64];
  logic [31:0] mbc;
  logic [31:0] mmc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mdl[i] = 2'b01;
    mbc = 0;
    mmc = 0;
  endtask

  task automatic drive_idle();
    bp_if.ex_valid      = 1'b0;
    bp_if.ex_is_branch  = 1'b0;
    bp_if.ex_br_type    = 1'b0;
    bp_if.ex_zero       = 1'b0;
    bp_if.ex_pred_taken = 1'b0;
    bp_if.ex_pc         = 32'h0;
  endtask

  // One cycle: drive after the edge, check at the falling edge, then advance the model.
  task automatic step(input logic v, input logic b, input logic bt, input logic z,
                      input logic p, input logic [31:0] pc, input logic [31:0] ifpc);
    exp_t e;
    logic [5:0] ii;
    logic [5:0] ei;
    @(posedge clk);
    #1;
    bp_if.ex_valid      = v;
    bp_if.ex_is_branch  = b;
    bp_if.ex_br_type    = bt;
    bp_if.ex_zero       = z;
    bp_if.ex_pred_taken = p;
    bp_if.ex_pc         = pc;
    bp_if.if_pc         = ifpc;
    ii = ifpc[7:2];
    ei = pc[7:2];
    e.act = (v && b) ? (bt ? !z : z) : 1'b0;
    e.mis = v && b && (e.act != p);
    e.ifp = mdl[ii][1];
    e.bc  = mbc;
    e.mc  = mmc;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk("ex_actual_taken", {31'b0, bp_if.ex_actual_taken}, {31'b0, e.act});
    chk("ex_mispredict",   {31'b0, bp_if.ex_mispredict},   {31'b0, e.mis});
    chk("if_pred_taken",   {31'b0, bp_if.if_pred_taken},   {31'b0, e.ifp});
    chk("branch_count",     bp_if.branch_count,     e.bc);
    chk("mispredict_count", bp_if.mispredict_count, e.mc);
    if (v && b) begin
      if (e.act && mdl[ei] != 2'b11) mdl[ei] = mdl[ei] + 2'd1;
      else if (!e.act && mdl[ei] != 2'b00) mdl[ei] = mdl[ei] - 2'd1;
      mbc = mbc + 1;
      if (e.mis) mmc = mmc + 1;
    end
  endtask

  task automatic idle(input logic [31:0] ifpc);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, ifpc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 64; i += 9) begin
      bp_if.if_pc = i * 4;
      #1;
      chk("reset_pred", {31'b0, bp_if.if_pred_taken}, 32'h0);
    end
    chk("reset_bc", bp_if.branch_count, 32'h0);
    chk("reset_mc", bp_if.mispredict_count, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    tests  = 0;
    failed = 0;
    rst_n  = 1'b1;
    bp_if.if_pc = 32'h0;
    drive_idle();
    model_reset();

    //           v     b     bt    z     p     pc        act   mis
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h040, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h044, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h048, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h04c, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h050, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h054, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h058, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h041, 1'b1, 1'b0};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].v, vecs[i].b, vecs[i].bt, vecs[i].z, vecs[i].p, vecs[i].pc, vecs[i].pc);
      chk("vec_act", {31'b0, bp_if.ex_actual_taken}, {31'b0, vecs[i].exp_act});
      chk("vec_mis", {31'b0, bp_if.ex_mispredict},   {31'b0, vecs[i].exp_mis});
      idle(vecs[i].pc);
    end

    // First taken BEQ at 0x40 from reset.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    chk("beq40_act", {31'b0, bp_if.ex_actual_taken}, 32'h1);
    chk("beq40_mis", {31'b0, bp_if.ex_mispredict},   32'h1);
    idle(32'h40);
    chk("beq40_pred", {31'b0, bp_if.if_pred_taken}, 32'h1);
    chk("beq40_bc", bp_if.branch_count, 32'h1);
    chk("beq40_mc", bp_if.mispredict_count, 32'h1);

    // Saturation toward strong-taken, then two not-taken steps back to weak-NT.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h80);
      chk("sat_t_pred", {31'b0, bp_if.if_pred_taken}, (k == 0) ? 32'h0 : 32'h1);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h80);
    chk("sat_t_nt1", {31'b0, bp_if.if_pred_taken}, 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h80);
    chk("sat_t_nt2", {31'b0, bp_if.if_pred_taken}, 32'h1);
    idle(32'h80);
    chk("sat_t_end", {31'b0, bp_if.if_pred_taken}, 32'h0);

    // BNE not-taken saturates at strong-NT; one taken only reaches weak-NT.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, (k == 1), 32'h100, 32'h100);
      chk("bne_act", {31'b0, bp_if.ex_actual_taken}, 32'h0);
    end
    idle(32'h100);
    chk("bne_pred", {31'b0, bp_if.if_pred_taken}, 32'h0);
    chk("bne_bc", bp_if.branch_count, 32'h3);
    chk("bne_mc", bp_if.mispredict_count, 32'h1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h100);
    idle(32'h100);
    chk("bne_floor", {31'b0, bp_if.if_pred_taken}, 32'h0);
    chk("bne_mc2", bp_if.mispredict_count, 32'h2);

    // Same-index read during update sees the old value; aliasing at 0x120.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h20);
    chk("rw_same", {31'b0, bp_if.if_pred_taken}, 32'h0);
    idle(32'h20);
    chk("rw_next", {31'b0, bp_if.if_pred_taken}, 32'h1);
    idle(32'h120);
    chk("alias", {31'b0, bp_if.if_pred_taken}, 32'h1);
    idle(32'h24);
    chk("neighbour", {31'b0, bp_if.if_pred_taken}, 32'h0);

    // Non-branch with a taken prediction changes nothing.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h24, 32'h24);
    chk("nb_mis", {31'b0, bp_if.ex_mispredict}, 32'h0);
    idle(32'h24);
    chk("nb_pred", {31'b0, bp_if.if_pred_taken}, 32'h0);
    chk("nb_bc", bp_if.branch_count, 32'h1);
    chk("nb_mc", bp_if.mispredict_count, 32'h1);

    // Async reset pulse between edges clears state immediately.
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_bc", bp_if.branch_count, 32'h0);
    chk("arst_mc", bp_if.mispredict_count, 32'h0);
    bp_if.if_pc = 32'h20;
    #1;
    chk("arst_pred", {31'b0, bp_if.if_pred_taken}, 32'h0);
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'h20);
    idle(32'h20);
    chk("post_rst_pred", {31'b0, bp_if.if_pred_taken}, 32'h1);
    chk("post_rst_bc", bp_if.branch_count, 32'h1);
    chk("post_rst_mc", bp_if.mispredict_count, 32'h0);

    chk("sb_empty", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
